// File: rtl/seg7_if.sv
// Segment loopback bundle: raw pattern in, decoded
// digit and status flags out.
interface seg7_if;
  logic [6:0] seg_in;
  logic [3:0] value;
  logic       valid;
  logic       blank;
  logic       err;
  logic       upd;

  modport master (
    output seg_in,
    input  value, valid, blank, err, upd
  );

  modport slave (
    input  seg_in,
    output value, valid, blank, err, upd
  );
endinterface

// File: rtl/seg7_decoder.sv
// Active-low 7-segment pattern to hex decoder with
// stability qualification and blank/illegal flags.
module seg7_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic  clk,
  input  logic  rst,
  seg7_if.slave bus
);
  typedef enum logic {ACQUIRE, LOCKED} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_PRE =
    CNT_W'(STABLE_CYCLES - 2);

  state_t           state, state_n;
  logic [6:0]       s, s_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             commit;

  logic [3:0]       dig;
  logic             legal;
  logic             is_blank;
  logic [3:0]       nxt_value;
  logic             nxt_err;

  always_comb begin
    state_n = state;
    s_n     = s;
    cnt_n   = cnt;
    commit  = 1'b0;
    unique case (state)
      ACQUIRE: begin
        if (bus.seg_in != s) begin
          s_n   = bus.seg_in;
          cnt_n = '0;
        end else if (cnt == CNT_PRE) begin
          cnt_n   = CNT_MAX;
          commit  = 1'b1;
          state_n = LOCKED;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      LOCKED: begin
        if (bus.seg_in != s) begin
          s_n     = bus.seg_in;
          cnt_n   = '0;
          state_n = ACQUIRE;
        end
      end
      default: state_n = LOCKED;
    endcase
  end

  // s equals seg_in on a commit edge, so decode the register
  always_comb begin
    {legal, dig} = 5'h00;
    unique case (s)
      7'b1000000: {legal, dig} = 5'h10;
      7'b1111001: {legal, dig} = 5'h11;
      7'b0100100: {legal, dig} = 5'h12;
      7'b0110000: {legal, dig} = 5'h13;
      7'b0011001: {legal, dig} = 5'h14;
      7'b0010010: {legal, dig} = 5'h15;
      7'b0000010: {legal, dig} = 5'h16;
      7'b1111000: {legal, dig} = 5'h17;
      7'b0000000: {legal, dig} = 5'h18;
      7'b0010000: {legal, dig} = 5'h19;
      7'b0001000: {legal, dig} = 5'h1A;
      7'b0000011: {legal, dig} = 5'h1B;
      7'b1000110: {legal, dig} = 5'h1C;
      7'b0100001: {legal, dig} = 5'h1D;
      7'b0000110: {legal, dig} = 5'h1E;
      7'b0001110: {legal, dig} = 5'h1F;
      default:    {legal, dig} = 5'h00;
    endcase
  end

  assign is_blank  = (s == 7'h7F);
  assign nxt_value = legal ? dig : bus.value;
  assign nxt_err   = !legal && !is_blank;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOCKED;
      s     <= 7'h7F;
      cnt   <= CNT_MAX;
    end else begin
      state <= state_n;
      s     <= s_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.value <= 4'h0;
      bus.valid <= 1'b0;
      bus.blank <= 1'b1;
      bus.err   <= 1'b0;
      bus.upd   <= 1'b0;
    end else if (commit) begin
      bus.value <= nxt_value;
      bus.valid <= legal;
      bus.blank <= is_blank;
      bus.err   <= nxt_err;
      bus.upd   <=
        {nxt_value, legal, is_blank, nxt_err} !=
        {bus.value, bus.valid, bus.blank, bus.err};
    end else begin
      bus.upd <= 1'b0;
    end
  end
endmodule

// File: tb/tb_seg7_decoder.sv
// Scoreboard bench: run-length reference model for
// two decoder instances (4- and 2-cycle qualification).
module tb_seg7_decoder;
  typedef struct {
    int         at;
    logic [3:0] v;
    logic       va;
    logic       bl;
    logic       er;
  } exp_t;

  logic       clk;
  logic       clk_en;
  logic       rst;
  logic [6:0] seg;

  int n_chk;
  int n_fail;
  int edge_cnt;

  seg7_if bus4 ();
  seg7_if bus2 ();

  assign bus4.seg_in = seg;
  assign bus2.seg_in = seg;

  seg7_decoder #(.STABLE_CYCLES(4), .CNT_W(8)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  seg7_decoder #(.STABLE_CYCLES(2), .CNT_W(8)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  logic [6:0] glyph [16];
  int         sc [2];
  logic [6:0] run_val [2];
  int         run_len [2];
  logic [3:0] cur_v [2];
  logic       cur_va [2];
  logic       cur_bl [2];
  logic       cur_er [2];
  exp_t       q0 [$];
  exp_t       q1 [$];

  initial begin
    glyph = '{7'b1000000, 7'b1111001, 7'b0100100,
              7'b0110000, 7'b0011001, 7'b0010010,
              7'b0000010, 7'b1111000, 7'b0000000,
              7'b0010000, 7'b0001000, 7'b0000011,
              7'b1000110, 7'b0100001, 7'b0000110,
              7'b0001110};
    sc = '{4, 2};
  end

  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      run_val[k] = 7'h7F;
      run_len[k] = 1000;
      cur_v[k]   = 4'h0;
      cur_va[k]  = 1'b0;
      cur_bl[k]  = 1'b1;
      cur_er[k]  = 1'b0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic model_commit(input int k);
    exp_t x;
    x.at = edge_cnt;
    x.v  = cur_v[k];
    x.va = 1'b0;
    x.bl = (run_val[k] == 7'h7F);
    x.er = !x.bl;
    for (int d = 0; d < 16; d++)
      if (glyph[d] == run_val[k]) begin
        x.v  = 4'(d);
        x.va = 1'b1;
        x.er = 1'b0;
      end
    if ({x.v, x.va, x.bl, x.er} !=
        {cur_v[k], cur_va[k], cur_bl[k], cur_er[k]}) begin
      if (k == 0) q0.push_back(x);
      else        q1.push_back(x);
    end
    cur_v[k]  = x.v;
    cur_va[k] = x.va;
    cur_bl[k] = x.bl;
    cur_er[k] = x.er;
  endtask

  // a commit fires when the run of identical samples
  // reaches the qualification length
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_reset();
    end else begin
      edge_cnt++;
      for (int k = 0; k < 2; k++) begin
        if (seg == run_val[k]) begin
          if (run_len[k] < 1000) run_len[k]++;
        end else begin
          run_val[k] = seg;
          run_len[k] = 1;
        end
        if (run_len[k] == sc[k]) model_commit(k);
      end
    end
  end

  task automatic check(input string name,
                       input logic [7:0] act,
                       input logic [7:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               name, act, req);
    end
  endtask

  task automatic check_dut(input int k,
                           input logic [3:0] v,
                           input logic va, bl, er, up);
    exp_t x;
    logic pulse;
    pulse = 1'b0;
    if (k == 0) begin
      if (q0.size() > 0 && q0[0].at <= edge_cnt) begin
        x = q0.pop_front();
        pulse = 1'b1;
      end
    end else begin
      if (q1.size() > 0 && q1[0].at <= edge_cnt) begin
        x = q1.pop_front();
        pulse = 1'b1;
      end
    end
    check($sformatf("upd[sc%0d]", sc[k]),
          {7'd0, up}, {7'd0, pulse});
    if (pulse) begin
      check($sformatf("commit_at[sc%0d]", sc[k]),
            8'(edge_cnt), 8'(x.at));
      check($sformatf("commit_out[sc%0d]", sc[k]),
            {1'b0, v, va, bl, er},
            {1'b0, x.v, x.va, x.bl, x.er});
    end
    check($sformatf("outputs[sc%0d]", sc[k]),
          {1'b0, v, va, bl, er},
          {1'b0, cur_v[k], cur_va[k], cur_bl[k], cur_er[k]});
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check_dut(0, bus4.value, bus4.valid,
                bus4.blank, bus4.err, bus4.upd);
      check_dut(1, bus2.value, bus2.valid,
                bus2.blank, bus2.err, bus2.upd);
    end
  end

  task automatic chk_reset(input string name);
    check({name, "_sc4"},
          {3'd0, bus4.value, bus4.valid, bus4.blank,
           bus4.err, bus4.upd},
          8'b0000_0100);
    check({name, "_sc2"},
          {3'd0, bus2.value, bus2.valid, bus2.blank,
           bus2.err, bus2.upd},
          8'b0000_0100);
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic [6:0] p, input int n);
    seg = p;
    hold(n);
  endtask

  initial begin
    int r;
    logic [6:0] p;
    n_chk    = 0;
    n_fail   = 0;
    edge_cnt = 0;
    clk_en   = 1'b0;
    rst      = 1'b0;
    seg      = 7'b0000010;
    #1 rst = 1'b1;
    #20;
    chk_reset("reset_noclk");
    clk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    hold(6);
    check("digit6_after_reset", {4'd0, bus4.value},
          8'h06);

    for (int d = 0; d < 16; d++) drive(glyph[d], 6);

    drive(glyph[3], 6);
    drive(glyph[8], 2);
    drive(glyph[3], 6);

    drive(7'b1010101, 5);
    check("illegal_err", {6'd0, bus4.err, bus4.valid},
          8'h02);
    check("illegal_holds", {4'd0, bus4.value}, 8'h03);
    drive(7'h7F, 5);
    check("blank_flag", {6'd0, bus4.blank, bus4.err},
          8'h02);

    drive(glyph[5], 6);
    drive(glyph[1], 3);
    drive(glyph[5], 6);

    drive(glyph[9], 2);
    #2 rst = 1'b1;
    #1 chk_reset("reset_mid_acquire");
    @(negedge clk);
    rst = 1'b0;
    hold(6);
    check("digit9_after_reset", {4'd0, bus4.value},
          8'h09);

    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7)       p = glyph[$urandom_range(0, 15)];
      else if (r == 7) p = 7'h7F;
      else             p = 7'($urandom);
      drive(p, int'($urandom_range(1, 6)));
    end
    hold(6);
    check("queue_drained",
          8'(q0.size() + q1.size()), 8'd0);

    $display("%0d/%0d checks passed",
             n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/seg7_decoder.md
Name: seg7_decoder

Overview:
Inverse of the team's hex-to-7-segment driver. It samples an active-low 7-segment pattern, waits until the pattern has been stable for a programmable number of cycles, and then decodes it back to a 4-bit hex value. It also flags blank and illegal patterns. It sits on the verification/loopback path after the segment driver, for example to check what the board display actually shows, and feeds status LEDs or a scoreboard.

Parameters:
STABLE_CYCLES, 4, number of consecutive identical samples needed before a pattern is committed; legal range 2..255.
CNT_W, 8, width of the stability counter; must satisfy 2^CNT_W > STABLE_CYCLES.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  asynchronous reset, active-high.
seg_in  input  7  active-low segment pattern, bit order {g,f,e,d,c,b,a}; asynchronous to the display logic, treated as raw data.
value  output  4  last committed decoded hex digit.
valid  output  1  high when the committed pattern is a legal hex glyph.
blank  output  1  high when the committed pattern is 7'b1111111.
err  output  1  high when the committed pattern is neither a legal glyph nor blank.
upd  output  1  one-cycle pulse when the committed result changes.

Behaviour:
- Reset (asynchronous, rst=1): value=0, valid=0, blank=1, err=0, upd=0. Internal sample register s=7'h7F, cnt=STABLE_CYCLES-1, state=LOCKED (locked on blank).
- Decode table (active-low, {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
  - blank=1111111. Any other pattern is illegal.
- State machine. There are two states, and all updates happen on the clk rising edge.
  - ACQUIRE: a new pattern is being qualified.
    - If seg_in != s: s<=seg_in, cnt<=0, stay in ACQUIRE.
    - Else if cnt == STABLE_CYCLES-2: cnt<=STABLE_CYCLES-1, commit, go to LOCKED.
    - Else: cnt<=cnt+1.
  - LOCKED: counter saturated, outputs reflect s.
    - If seg_in != s: s<=seg_in, cnt<=0, go to ACQUIRE.
    - Otherwise hold; no re-commit and no upd.
- Commit, registered on the same edge as the LOCKED transition:
  - Legal glyph: value<=digit, valid<=1, blank<=0, err<=0.
  - Blank: valid<=0, blank<=1, err<=0; value holds its previous value.
  - Illegal pattern: valid<=0, blank<=0, err<=1; value holds its previous value.
- Exactly one of valid/blank/err is high at all times after reset.
- upd<=1 on the commit edge only if the new {value,valid,blank,err} differs from the current one; otherwise upd<=0. upd is 0 on every non-commit cycle.
- Latency: if seg_in changes and then stays steady, the first edge loads s. Outputs update STABLE_CYCLES-1 edges after that, so the total is STABLE_CYCLES edges after the change.
- Glitch rejection: any mismatch restarts qualification (cnt<=0). Committed outputs do not change while in ACQUIRE; they keep the last committed result.
- A pattern that changes and then returns to the same code before commit still requires a full STABLE_CYCLES requalification. If it commits the same result, upd stays 0.
- Reset mid-ACQUIRE discards the partial qualification and restores the reset values immediately, without waiting for a clock edge.

Test Plan:
1. Reset behaviour: assert rst with seg_in=0000010 and no clock running -> value=0, valid=0, blank=1, err=0, upd=0. Release rst with seg_in held -> valid=1 and value=6 on the 4th edge after release, upd high for exactly 1 cycle.
2. Full table sweep: drive all 16 glyphs, each held for 6 cycles, with STABLE_CYCLES=4 -> value follows 0..F, valid=1, err=0, and one upd pulse per glyph, each 4 edges after the change.
3. Glitch rejection: while locked on 3, drive 0110000 -> 0000000 for 2 cycles -> back to 0110000 -> value stays 3 throughout and upd is never asserted.
4. Illegal pattern and blank: drive 1010101 for 5 cycles -> err=1, valid=0, value holds its previous digit. Then drive 1111111 for 5 cycles -> blank=1, err=0, one upd pulse for each commit.
5. Boundary timing: with STABLE_CYCLES=2, a pattern held for exactly 2 edges commits. With the default of 4, a pattern held for only 3 edges does not commit.
6. Asynchronous reset mid-ACQUIRE: after 2 stable cycles of pattern 9, assert rst between clock edges -> outputs return to reset values immediately. After release, pattern 9 needs 4 full edges to commit.
